// File: rtl/axil_pkg.sv
// ============================================================================
// Module  : axil_pkg
// Brief   : Shared types for the AXI4-Lite command/response initiator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axil_pkg;

    localparam int c_MAX_ADDR_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    typedef struct packed {
        logic                    write;
        logic [c_MAX_ADDR_W-1:0] addr;
        logic [31:0]             wdata;
        logic [3:0]              wstrb;
    } axil_cmd_t;

endpackage

`default_nettype wire

// File: rtl/axil_master_if.sv
// ============================================================================
// Module  : axil_master_if
// Brief   : Command/response handshake plus AXI4-Lite master bus signals.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axil_master_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] M_AXI_awaddr;
    logic [2:0]            M_AXI_awprot;
    logic                  M_AXI_awvalid;
    logic                  M_AXI_awready;
    logic [31:0]           M_AXI_wdata;
    logic [3:0]            M_AXI_wstrb;
    logic                  M_AXI_wvalid;
    logic                  M_AXI_wready;
    logic [1:0]            M_AXI_bresp;
    logic                  M_AXI_bvalid;
    logic                  M_AXI_bready;
    logic [ADDR_WIDTH-1:0] M_AXI_araddr;
    logic [2:0]            M_AXI_arprot;
    logic                  M_AXI_arvalid;
    logic                  M_AXI_arready;
    logic [31:0]           M_AXI_rdata;
    logic [1:0]            M_AXI_rresp;
    logic                  M_AXI_rvalid;
    logic                  M_AXI_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  M_AXI_awready, M_AXI_wready, M_AXI_bresp, M_AXI_bvalid,
        input  M_AXI_arready, M_AXI_rdata, M_AXI_rresp, M_AXI_rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output M_AXI_awaddr, M_AXI_awprot, M_AXI_awvalid,
        output M_AXI_wdata, M_AXI_wstrb, M_AXI_wvalid, M_AXI_bready,
        output M_AXI_araddr, M_AXI_arprot, M_AXI_arvalid, M_AXI_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output M_AXI_awready, M_AXI_wready, M_AXI_bresp, M_AXI_bvalid,
        output M_AXI_arready, M_AXI_rdata, M_AXI_rresp, M_AXI_rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  M_AXI_awaddr, M_AXI_awprot, M_AXI_awvalid,
        input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wvalid, M_AXI_bready,
        input  M_AXI_araddr, M_AXI_arprot, M_AXI_arvalid, M_AXI_rready
    );

endinterface

`default_nettype wire

// File: rtl/axil_master.sv
// ============================================================================
// Module  : axil_master
// Brief   : One-at-a-time command/response to single-beat AXI4-Lite initiator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int TIMEOUT    = 256
) (
    input  wire logic          axi_aclk,
    input  wire logic          axi_areset,
    axil_master_if.master      bus
);

    localparam int                    c_CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0]    c_TMO_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MASK = ~ADDR_WIDTH'(3);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_abort;
    axil_cmd_t             w_cmd;
    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_busy, w_tmo_hit;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_aw_done, r_w_done;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    resp_t                 r_rsp_resp;
    logic                  r_rsp_timeout;

    always_comb begin
        w_cmd       = '0;
        w_cmd.write = bus.cmd_write;
        w_cmd.addr  = c_MAX_ADDR_W'(bus.cmd_addr & c_ADDR_MASK);
        w_cmd.wdata = bus.cmd_wdata;
        w_cmd.wstrb = bus.cmd_wstrb;
    end

    assign w_aw_hs   = r_awvalid & bus.M_AXI_awready;
    assign w_w_hs    = r_wvalid & bus.M_AXI_wready;
    assign w_ar_hs   = r_arvalid & bus.M_AXI_arready;
    assign w_busy    = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                       (r_state == RD_REQ) || (r_state == RD_RESP);
    assign w_tmo_hit = (TIMEOUT != 0) && w_busy && (r_cnt == c_TMO_LAST);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // A completing handshake takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            IDLE:    if (bus.cmd_valid) w_state_nxt = w_cmd.write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_nxt = WR_RESP;
                     else if (w_tmo_hit) w_abort = 1'b1;
            WR_RESP: if (r_bready && bus.M_AXI_bvalid) w_state_nxt = RSP;
                     else if (w_tmo_hit) w_abort = 1'b1;
            RD_REQ:  if (w_ar_hs) w_state_nxt = RD_RESP;
                     else if (w_tmo_hit) w_abort = 1'b1;
            RD_RESP: if (r_rready && bus.M_AXI_rvalid) w_state_nxt = RSP;
                     else if (w_tmo_hit) w_abort = 1'b1;
            RSP:     if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = RSP;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset)                                 r_cnt <= '0;
        else if (TIMEOUT == 0 || w_state_nxt != r_state) r_cnt <= '0;
        else if (w_busy)                                r_cnt <= r_cnt + c_CNT_W'(1);
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= OKAY;
            r_rsp_timeout <= 1'b0;
        end else if (w_abort) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= SLVERR;
            r_rsp_timeout <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (w_cmd.write) begin
                        r_awaddr  <= w_cmd.addr[ADDR_WIDTH-1:0];
                        r_wdata   <= w_cmd.wdata;
                        r_wstrb   <= w_cmd.wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end else begin
                        r_araddr  <= w_cmd.addr[ADDR_WIDTH-1:0];
                        r_arvalid <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_state_nxt == WR_RESP) r_bready <= 1'b1;
                end
                WR_RESP: if (w_state_nxt == RSP) begin
                    r_bready      <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_rdata   <= '0;
                    r_rsp_resp    <= resp_t'(bus.M_AXI_bresp);
                    r_rsp_timeout <= 1'b0;
                end
                RD_REQ: if (w_state_nxt == RD_RESP) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                end
                RD_RESP: if (w_state_nxt == RSP) begin
                    r_rready      <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_rdata   <= bus.M_AXI_rdata;
                    r_rsp_resp    <= resp_t'(bus.M_AXI_rresp);
                    r_rsp_timeout <= 1'b0;
                end
                RSP: if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready     = (r_state == IDLE);
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_resp      = r_rsp_resp;
    assign bus.rsp_timeout   = r_rsp_timeout;
    assign bus.M_AXI_awaddr  = r_awaddr;
    assign bus.M_AXI_awprot  = 3'b000;
    assign bus.M_AXI_awvalid = r_awvalid;
    assign bus.M_AXI_wdata   = r_wdata;
    assign bus.M_AXI_wstrb   = r_wstrb;
    assign bus.M_AXI_wvalid  = r_wvalid;
    assign bus.M_AXI_bready  = r_bready;
    assign bus.M_AXI_araddr  = r_araddr;
    assign bus.M_AXI_arprot  = 3'b000;
    assign bus.M_AXI_arvalid = r_arvalid;
    assign bus.M_AXI_rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axil_master.sv
// ============================================================================
// Module  : tb_axil_master
// Brief   : Scoreboarded bench for axil_master against a 32-register responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axil_master;
    import axil_pkg::*;

    localparam int c_AW  = 7;
    localparam int c_TMO = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_master_if #(.ADDR_WIDTH(c_AW)) bus();

    axil_master #(.ADDR_WIDTH(c_AW), .TIMEOUT(c_TMO)) u_dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .bus        (bus)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic [1:0] resp, input logic tmo);
        exp_t e;
        e.rdata = rdata;
        e.resp  = resp;
        e.tmo   = tmo;
        return e;
    endfunction

    // Responder: 32-word register file with programmable awready delay and bvalid suppression.
    int          aw_delay = 0;
    bit          no_bresp = 1'b0;
    bit          ar_stall = 1'b0;
    int          aw_wait;
    logic [31:0] mem [32];
    logic        have_aw, have_w, got_aw, got_w;
    logic [6:0]  pend_addr, wr_addr;
    logic [31:0] pend_data, wr_data;
    logic [3:0]  pend_strb, wr_strb;
    logic        s_bvalid, s_rvalid;
    logic [31:0] s_rdata;

    assign bus.M_AXI_awready = bus.M_AXI_awvalid && (aw_wait >= aw_delay);
    assign bus.M_AXI_wready  = 1'b1;
    assign bus.M_AXI_arready = !ar_stall;
    assign bus.M_AXI_bvalid  = s_bvalid;
    assign bus.M_AXI_bresp   = 2'b00;
    assign bus.M_AXI_rvalid  = s_rvalid;
    assign bus.M_AXI_rdata   = s_rdata;
    assign bus.M_AXI_rresp   = 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0]    <= 32'hdeadbeef;
            mem[1]    <= 32'h76543210;
            mem[7]    <= 32'hAAAAAAAA;
            aw_wait   <= 0;
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            pend_strb <= '0;
            s_bvalid  <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
        end else begin
            got_aw  = have_aw || (bus.M_AXI_awvalid && bus.M_AXI_awready);
            got_w   = have_w  || (bus.M_AXI_wvalid && bus.M_AXI_wready);
            wr_addr = have_aw ? pend_addr : bus.M_AXI_awaddr;
            wr_data = have_w  ? pend_data : bus.M_AXI_wdata;
            wr_strb = have_w  ? pend_strb : bus.M_AXI_wstrb;
            aw_wait <= (bus.M_AXI_awvalid && !bus.M_AXI_awready) ? aw_wait + 1 : 0;
            if (got_aw && got_w && !s_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[6:2]][8*b +: 8] <= wr_data[8*b +: 8];
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
                s_bvalid <= !no_bresp;
            end else begin
                if (bus.M_AXI_awvalid && bus.M_AXI_awready) begin
                    have_aw   <= 1'b1;
                    pend_addr <= bus.M_AXI_awaddr;
                end
                if (bus.M_AXI_wvalid && bus.M_AXI_wready) begin
                    have_w    <= 1'b1;
                    pend_data <= bus.M_AXI_wdata;
                    pend_strb <= bus.M_AXI_wstrb;
                end
            end
            if (s_bvalid && bus.M_AXI_bready) s_bvalid <= 1'b0;
            if (bus.M_AXI_arvalid && bus.M_AXI_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[bus.M_AXI_araddr[6:2]];
            end else if (s_rvalid && bus.M_AXI_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // Channel activity counters, cleared on request from the stimulus.
    bit cnt_clr = 1'b0;
    int cnt_aw, cnt_w, cnt_b;
    always @(posedge clk) begin
        if (cnt_clr) begin
            cnt_aw <= 0;
            cnt_w  <= 0;
            cnt_b  <= 0;
        end else begin
            if (bus.M_AXI_awvalid) cnt_aw <= cnt_aw + 1;
            if (bus.M_AXI_wvalid)  cnt_w  <= cnt_w + 1;
            if (bus.M_AXI_bvalid && bus.M_AXI_bready) cnt_b <= cnt_b + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}, 64'(e));
            end
        end
    end

    task automatic issue(input bit wr, input logic [6:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_wstrb = ws;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'hFFFFFFFF;
        bus.cmd_wstrb = 4'hF;
    endtask

    task automatic wait_rsp_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("rsp_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_cmd(input bit wr, input logic [6:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [6:0] exp_addr, input exp_t e,
                          input bit chk_lat);
        int lat;
        exp_q.push_back(e);
        issue(wr, addr, wd, ws);
        if (wr) begin
            check("aw_w_valid", {bus.M_AXI_awvalid, bus.M_AXI_wvalid}, 64'b11);
            check("awaddr", 64'(bus.M_AXI_awaddr), 64'(exp_addr));
        end else begin
            check("arvalid", 64'(bus.M_AXI_arvalid), 64'd1);
            check("araddr", 64'(bus.M_AXI_araddr), 64'(exp_addr));
        end
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) check("latency", 64'(lat), 64'd3);
        wait_rsp_drained();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        logic [34:0] snap;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}, 64'd0);
        check("rst_axi_vr", {bus.M_AXI_awvalid, bus.M_AXI_wvalid, bus.M_AXI_bready,
                             bus.M_AXI_arvalid, bus.M_AXI_rready}, 64'd0);
        check("rst_axi_data", {bus.M_AXI_awaddr, bus.M_AXI_araddr, bus.M_AXI_wdata, bus.M_AXI_wstrb}, 64'd0);
        rst = 1'b0;

        do_cmd(1'b1, 7'h20, 32'h12345678, 4'hF, 7'h20, mk(32'h0, 2'b00, 1'b0), 1'b1);
        do_cmd(1'b0, 7'h20, 32'h0, 4'h0, 7'h20, mk(32'h12345678, 2'b00, 1'b0), 1'b1);
        do_cmd(1'b0, 7'h00, 32'h0, 4'h0, 7'h00, mk(32'hdeadbeef, 2'b00, 1'b0), 1'b1);
        do_cmd(1'b0, 7'h04, 32'h0, 4'h0, 7'h04, mk(32'h76543210, 2'b00, 1'b0), 1'b1);
        do_cmd(1'b0, 7'h05, 32'h0, 4'h0, 7'h04, mk(32'h76543210, 2'b00, 1'b0), 1'b1);

        do_cmd(1'b1, 7'h1C, 32'h55555555, 4'b0011, 7'h1C, mk(32'h0, 2'b00, 1'b0), 1'b1);
        do_cmd(1'b0, 7'h1C, 32'h0, 4'h0, 7'h1C, mk(32'hAAAA5555, 2'b00, 1'b0), 1'b1);

        aw_delay = 10;
        @(negedge clk) cnt_clr = 1'b1;
        @(negedge clk) cnt_clr = 1'b0;
        do_cmd(1'b1, 7'h0B, 32'hCAFEF00D, 4'hF, 7'h08, mk(32'h0, 2'b00, 1'b0), 1'b0);
        check("awvalid_cycles", 64'(cnt_aw), 64'd11);
        check("wvalid_cycles", 64'(cnt_w), 64'd1);
        check("b_handshakes", 64'(cnt_b), 64'd1);
        aw_delay = 0;
        do_cmd(1'b0, 7'h08, 32'h0, 4'h0, 7'h08, mk(32'hCAFEF00D, 2'b00, 1'b0), 1'b1);

        // Write whose response never comes back; the response is held off for 5 cycles.
        no_bresp = 1'b1;
        bus.rsp_ready = 1'b0;
        exp_q.push_back(mk(32'h0, 2'b10, 1'b1));
        issue(1'b1, 7'h0C, 32'h00000001, 4'hF);
        n = 0;
        while (!bus.M_AXI_bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bready_seen", 64'(bus.M_AXI_bready), 64'd1);
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_latency", 64'(lat), 64'd16);
        snap = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout};
        check("timeout_rsp", 64'(snap), {29'd0, 32'h0, 2'b10, 1'b1});
        check("timeout_axi_idle", {bus.M_AXI_awvalid, bus.M_AXI_wvalid, bus.M_AXI_bready,
                                   bus.M_AXI_arvalid, bus.M_AXI_rready}, 64'd0);
        repeat (5) begin
            @(negedge clk);
            check("rsp_stable", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout},
                  {28'd0, 1'b1, 32'h0, 2'b10, 1'b1});
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_rsp_drained();
        no_bresp = 1'b0;

        ar_stall = 1'b1;
        issue(1'b0, 7'h00, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        check("arvalid_stalled", 64'(bus.M_AXI_arvalid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valids", {bus.M_AXI_awvalid, bus.M_AXI_wvalid, bus.M_AXI_arvalid,
                                 bus.M_AXI_bready, bus.M_AXI_rready}, 64'd0);
        check("rst_mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ar_stall = 1'b0;
        do_cmd(1'b0, 7'h04, 32'h0, 4'h0, 7'h04, mk(32'h76543210, 2'b00, 1'b0), 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axil_master.md
# axil_master

AXI4-Lite initiator that turns a simple one-at-a-time command/response handshake into single-beat AXI4-Lite read and write transactions. It drives the slave side of the PL register files, such as the GPS emulator control registers, from PL logic or a testbench without going through the Zynq PS. It is the initiator end of the same bus the register-file responder serves. Exactly one transaction is outstanding at any time.

## Interface
Parameters:
- ADDR_WIDTH, default 7: AXI byte-address width; matches a 32-register file.
- TIMEOUT, default 256: cycles to wait for any one AXI handshake before aborting; 0 disables the timeout.

Ports:
- axi_aclk  in  1  clock; one clock for the whole block.
- axi_areset  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  transaction was aborted by the timeout.
- M_AXI_awaddr/awprot/awvalid/awready: AXI write-address channel.
- M_AXI_wdata/wstrb/wvalid/wready: AXI write-data channel.
- M_AXI_bresp/bvalid/bready: AXI write-response channel.
- M_AXI_araddr/arprot/arvalid/arready: AXI read-address channel.
- M_AXI_rdata/rresp/rvalid/rready: AXI read-data channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid, capture the command, then go to WR_REQ (write) or RD_REQ (read).
- Captured address: address bits [1:0] are forced to 0; awprot = arprot = 3'b000.
- WR_REQ: awvalid and wvalid assert together.
  - Each valid drops independently on its own handshake, using aw_done/w_done flags.
  - Handshakes on both channels, in either order or in the same cycle → WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp → RSP.
- RD_REQ: arvalid=1. On arready → RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp → RSP.
- RSP: rsp_valid=1; all rsp_* outputs are held stable until rsp_ready=1, then → IDLE.
- Timeout counter:
  - Cleared on every state entry; counts each cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - Reaching TIMEOUT: all AXI valids and readies deassert, rsp_resp=2'b10 (SLVERR), rsp_timeout=1, rsp_rdata=0 → RSP.
  - An aborted transaction is a debug recovery path only; the responder must be reset before further use.
- AXI rule: a valid, once asserted, is never deasserted without a handshake, except on timeout or reset.
- Response codes pass through unchanged; DECERR and SLVERR are not retried.

## Timing
- Reset values: cmd_ready=1 (state IDLE); rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0; all M_AXI valid, ready and address/data outputs 0.
- All outputs are registered, except cmd_ready, which is decoded from the state register.
- Command accepted at cycle N → awvalid/wvalid (or arvalid) high at N+1.
- Minimum latency, with a zero-wait responder: rsp_valid at N+3.
- Back-to-back commands: the next cmd_ready rises the cycle after the rsp handshake.
- Reset asserted mid-transaction: state returns to IDLE and outputs take reset values asynchronously; any partially issued AXI transaction is dropped, so the responder shares this reset.
- Write data is captured at command acceptance, so cmd_wdata may change afterwards.

## Structure
- Package axil_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - state_t enum for the FSM.
  - packed struct axil_cmd_t {write, addr, wdata, wstrb}.
- Single module; no sub-module is warranted. The timeout counter is inline, clog2(TIMEOUT+1) bits wide.

## Test plan
All directed scenarios run against the 32-register AXI register file (ADDR_WIDTH=7).
- Write 0x20 ← 0x12345678, then read 0x20 → rsp_rdata=0x12345678, rsp_resp=OKAY on both responses, rsp_timeout=0.
- Read 0x00 → 0xdeadbeef; read 0x04 → 0x76543210; cmd_addr=0x05 is issued as araddr 0x04.
- Reg 0x1C preloaded with 0xAAAAAAAA; write 0x55555555 with wstrb=4'b0011 → readback 0xAAAA5555.
- Responder delays awready 10 cycles and asserts wready immediately:
  - wvalid drops after 1 cycle; awvalid stays high for 11 cycles.
  - Exactly one bvalid handshake; response OKAY.
- TIMEOUT=16, responder never asserts bvalid:
  - rsp_valid exactly 16 cycles after entering WR_RESP, with rsp_resp=SLVERR, rsp_timeout=1.
  - With rsp_ready held low for 5 cycles, all rsp_* outputs stay stable.
- Reset pulsed while arvalid is high:
  - All M_AXI valids are 0 in the same cycle and cmd_ready=1.
  - After reset, a fresh read completes normally.
